// File: rtl/cond_exec_unit.sv
// Condition-execute unit: per-context NZCV flag storage, ARM condition evaluation,
// write-enable gating and a saturating count of squashed instructions.
module cond_exec_unit #(
  parameter int NUM_CTX    = 1,
  parameter int PIPE_STAGE = 0,
  parameter int NV_ALWAYS  = 0,
  parameter int CNT_W      = 16,
  localparam int CTXW      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [CTXW-1:0]  ctx_i,
  input  logic [3:0]       cond_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flag_w_i,
  input  logic             pcs_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             no_write_i,
  output logic             valid_o,
  output logic             cond_ex_o,
  output logic             pcs_o,
  output logic             reg_w_o,
  output logic             mem_w_o,
  output logic             ctx_err_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] skip_cnt_o
);

  localparam int BANK = 1 << CTXW;

  logic [3:0]       flag_bank [BANK];
  logic [3:0]       cur_flags;
  logic             out_of_range;
  logic             ctx_err;
  logic             cond_pass;
  logic             ce;
  logic             n_flag, z_flag, c_flag, v_flag;
  logic [5:0]       issue;
  logic [5:0]       issue_out;
  logic [CNT_W-1:0] skip_reg;

  assign out_of_range = ({1'b0, ctx_i} >= (CTXW + 1)'(NUM_CTX));
  assign ctx_err      = valid_i & out_of_range;

  // Bank is padded to a power of two so ctx_i never indexes past the array;
  // padding entries read as zero and are never written.
  genvar gi;
  generate
    for (gi = 0; gi < BANK; gi++) begin : g_ctx
      if (gi < NUM_CTX) begin : g_live
        logic [3:0] flag_reg;
        logic       hit;

        assign hit = ce && (ctx_i == CTXW'(gi));

        always_ff @(posedge clk) begin
          if (reset) begin
            flag_reg <= 4'b0000;
          end else if (hit) begin
            if (flag_w_i[1]) flag_reg[3:2] <= alu_flags_i[3:2];
            if (flag_w_i[0]) flag_reg[1:0] <= alu_flags_i[1:0];
          end
        end

        assign flag_bank[gi] = flag_reg;
      end else begin : g_pad
        assign flag_bank[gi] = 4'b0000;
      end
    end
  endgenerate

  assign cur_flags = flag_bank[ctx_i];
  assign flags_o   = cur_flags;
  assign {n_flag, z_flag, c_flag, v_flag} = cur_flags;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_i)
      4'h0: cond_pass = z_flag;
      4'h1: cond_pass = ~z_flag;
      4'h2: cond_pass = c_flag;
      4'h3: cond_pass = ~c_flag;
      4'h4: cond_pass = n_flag;
      4'h5: cond_pass = ~n_flag;
      4'h6: cond_pass = v_flag;
      4'h7: cond_pass = ~v_flag;
      4'h8: cond_pass = c_flag & ~z_flag;
      4'h9: cond_pass = ~c_flag | z_flag;
      4'hA: cond_pass = (n_flag == v_flag);
      4'hB: cond_pass = (n_flag != v_flag);
      4'hC: cond_pass = ~z_flag & (n_flag == v_flag);
      4'hD: cond_pass = z_flag | (n_flag != v_flag);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = (NV_ALWAYS != 0);
    endcase
  end

  assign ce    = valid_i & ~ctx_err & cond_pass;
  assign issue = {valid_i, ce, pcs_i & ce, reg_w_i & ce & ~no_write_i, mem_w_i & ce, ctx_err};

  always_ff @(posedge clk) begin
    if (reset) begin
      skip_reg <= '0;
    end else if (valid_i && !ce && (skip_reg != {CNT_W{1'b1}})) begin
      skip_reg <= skip_reg + 1'b1;
    end
  end

  assign skip_cnt_o = skip_reg;

  generate
    if (PIPE_STAGE != 0) begin : g_pipe
      logic [5:0] out_reg;

      always_ff @(posedge clk) begin
        if (reset) out_reg <= 6'b0;
        else       out_reg <= issue;
      end

      assign issue_out = out_reg;
    end else begin : g_comb
      assign issue_out = reset ? 6'b0 : issue;
    end
  endgenerate

  assign {valid_o, cond_ex_o, pcs_o, reg_w_o, mem_w_o, ctx_err_o} = issue_out;

endmodule
